// File: rtl/axil_register_wr.sv
// rtl/axil_register_wr.sv - AXI4-lite write-path register slice (AW, W, B channels)
// Each channel is independently bypass, simple buffer or skid buffer.
module axil_register_wr #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH/8,
  parameter int AW_REG_TYPE = 1,
  parameter int W_REG_TYPE  = 1,
  parameter int B_REG_TYPE  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready
);

  // Channel 0 = AW, 1 = W (both s->m), 2 = B (m->s); payload packed per channel.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    localparam int PW = (c == 0) ? ADDR_WIDTH + 3 : (c == 1) ? DATA_WIDTH + STRB_WIDTH : 2;
    localparam int RT = (c == 0) ? AW_REG_TYPE : (c == 1) ? W_REG_TYPE : B_REG_TYPE;

    logic [PW-1:0] in_data;
    logic [PW-1:0] out_data;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;

    if (c == 0) begin : g_aw
      assign in_data                        = {s_axil_awaddr, s_axil_awprot};
      assign in_valid                       = s_axil_awvalid;
      assign s_axil_awready                 = in_ready;
      assign {m_axil_awaddr, m_axil_awprot} = out_data;
      assign m_axil_awvalid                 = out_valid;
      assign out_ready                      = m_axil_awready;
    end else if (c == 1) begin : g_w
      assign in_data                      = {s_axil_wdata, s_axil_wstrb};
      assign in_valid                     = s_axil_wvalid;
      assign s_axil_wready                = in_ready;
      assign {m_axil_wdata, m_axil_wstrb} = out_data;
      assign m_axil_wvalid                = out_valid;
      assign out_ready                    = m_axil_wready;
    end else begin : g_b
      assign in_data       = m_axil_bresp;
      assign in_valid      = m_axil_bvalid;
      assign m_axil_bready = in_ready;
      assign s_axil_bresp  = out_data;
      assign s_axil_bvalid = out_valid;
      assign out_ready     = s_axil_bready;
    end

    if (RT == 0) begin : g_bypass
      assign out_data  = in_data;
      assign out_valid = in_valid;
      assign in_ready  = out_ready;
    end else if (RT == 1) begin : g_simple
      logic [PW-1:0] data_reg;
      logic          valid_reg;
      logic          ready_reg;
      logic          valid_next;

      always_comb begin
        valid_next = valid_reg;
        if (ready_reg) begin
          valid_next = in_valid;
        end else if (out_ready) begin
          valid_next = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= valid_next;
          ready_reg <= !valid_next;
          if (ready_reg) begin
            data_reg <= in_data;
          end
        end
      end

      assign out_data  = data_reg;
      assign out_valid = valid_reg;
      assign in_ready  = ready_reg;
    end else begin : g_skid
      logic [PW-1:0] data_reg;
      logic [PW-1:0] temp_reg;
      logic          valid_reg;
      logic          temp_valid_reg;
      logic          ready_reg;
      logic          ready_early;

      // Ready stays up while the temp slot is free to catch one beat in flight.
      assign ready_early = out_ready | (!temp_valid_reg & (!valid_reg | !in_valid));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg      <= 1'b0;
          temp_valid_reg <= 1'b0;
          ready_reg      <= 1'b0;
          data_reg       <= '0;
          temp_reg       <= '0;
        end else begin
          ready_reg <= ready_early;
          if (ready_reg) begin
            if (out_ready || !valid_reg) begin
              valid_reg <= in_valid;
              data_reg  <= in_data;
            end else begin
              temp_valid_reg <= in_valid;
              temp_reg       <= in_data;
            end
          end else if (out_ready) begin
            valid_reg      <= temp_valid_reg;
            data_reg       <= temp_reg;
            temp_valid_reg <= 1'b0;
          end
        end
      end

      assign out_data  = data_reg;
      assign out_valid = valid_reg;
      assign in_ready  = ready_reg;
    end
  end

endmodule

// File: tb/tb_axil_register_wr.sv
// tb/tb_axil_register_wr.sv - directed and randomized bench for axil_register_wr
// Instance i uses register type i on every channel; channel c: 0 AW, 1 W, 2 B.
module tb_axil_register_wr;
  logic clk;
  logic rst;

  logic [39:0] src_data  [3][3];
  logic        src_valid [3][3];
  logic        snk_ready [3][3];
  logic        src_ready [3][3];
  logic        dst_valid [3][3];
  logic [39:0] dst_data  [3][3];

  logic [39:0] plan      [3][3][8];
  int          plan_len  [3][3];
  int          plan_idx  [3][3];
  logic        dir_ready [3][3];
  logic        in_hs     [3][3];
  logic        held      [3][3];
  logic [39:0] held_data [3][3];
  logic [39:0] sb_mem    [3][3][4096];
  int          sb_wr     [3][3];
  int          sb_rd     [3][3];
  int          out_cnt   [3][3];
  int          checks = 0;
  int          errors = 0;

  localparam logic AW_V [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic AW_R [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [1:0] B_RESP [4] = '{2'd0, 2'd2, 2'd3, 2'd1};
  localparam logic W_R [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam int   W_IDX [8] = '{0, 0, 0, 0, 0, 1, 2, 3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  s_bresp;

    axil_register_wr #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4),
      .AW_REG_TYPE(i), .W_REG_TYPE(i), .B_REG_TYPE(i)
    ) dut (
      .clk(clk), .rst(rst),
      .s_axil_awaddr(src_data[i][0][34:3]), .s_axil_awprot(src_data[i][0][2:0]),
      .s_axil_awvalid(src_valid[i][0]), .s_axil_awready(src_ready[i][0]),
      .s_axil_wdata(src_data[i][1][35:4]), .s_axil_wstrb(src_data[i][1][3:0]),
      .s_axil_wvalid(src_valid[i][1]), .s_axil_wready(src_ready[i][1]),
      .s_axil_bresp(s_bresp), .s_axil_bvalid(dst_valid[i][2]), .s_axil_bready(snk_ready[i][2]),
      .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot),
      .m_axil_awvalid(dst_valid[i][0]), .m_axil_awready(snk_ready[i][0]),
      .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
      .m_axil_wvalid(dst_valid[i][1]), .m_axil_wready(snk_ready[i][1]),
      .m_axil_bresp(src_data[i][2][1:0]), .m_axil_bvalid(src_valid[i][2]),
      .m_axil_bready(src_ready[i][2])
    );

    assign dst_data[i][0] = {5'd0, m_awaddr, m_awprot};
    assign dst_data[i][1] = {4'd0, m_wdata, m_wstrb};
    assign dst_data[i][2] = {38'd0, s_bresp};
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] rand_payload(input int c);
    logic [31:0] r;
    logic [31:0] s;
    r = $urandom;
    s = $urandom;
    if (c == 0) return {5'd0, r, s[2:0]};
    if (c == 1) return {4'd0, r, s[3:0]};
    return {38'd0, s[1:0]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) for (int c = 0; c < 3; c++) begin
      src_valid[i][c] = 1'b0;
      src_data[i][c]  = '0;
      plan_len[i][c]  = 0;
      plan_idx[i][c]  = 0;
      in_hs[i][c]     = 1'b0;
      held[i][c]      = 1'b0;
      sb_wr[i][c]     = 0;
      sb_rd[i][c]     = 0;
      dir_ready[i][c] = 1'b1;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 1; i < 3; i++) for (int c = 0; c < 3; c++) begin
      check($sformatf("%s_rdy_i%0d_c%0d", tag, i, c), src_ready[i][c], 0);
      check($sformatf("%s_vld_i%0d_c%0d", tag, i, c), dst_valid[i][c], 0);
      check($sformatf("%s_dat_i%0d_c%0d", tag, i, c), dst_data[i][c], 0);
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) for (int c = 0; c < 3; c++) snk_ready[i][c] = dir_ready[i][c];
    #1;
    for (int i = 1; i < 3; i++) for (int c = 0; c < 3; c++)
      check($sformatf("rel_rdy_i%0d_c%0d", i, c), src_ready[i][c], 0);
  endtask

  task automatic check_empty(input string tag);
    for (int i = 0; i < 3; i++) for (int c = 0; c < 3; c++)
      check($sformatf("%s_empty_i%0d_c%0d", tag, i, c), 40'(sb_rd[i][c]), 40'(sb_wr[i][c]));
  endtask

  // Sample point, half a cycle away from the edge: protocol, bypass and scoreboard checks.
  task automatic sample();
    for (int i = 0; i < 3; i++) for (int c = 0; c < 3; c++) begin
      string t;
      t = $sformatf("i%0d_c%0d", i, c);
      if (held[i][c]) begin
        check({t, "_hold_v"}, dst_valid[i][c], 1);
        check({t, "_hold_d"}, dst_data[i][c], held_data[i][c]);
      end
      if (i == 0) begin
        check({t, "_byp_v"}, dst_valid[i][c], src_valid[i][c]);
        check({t, "_byp_d"}, dst_data[i][c], src_data[i][c]);
        check({t, "_byp_r"}, src_ready[i][c], snk_ready[i][c]);
      end
      in_hs[i][c] = src_valid[i][c] && src_ready[i][c];
      if (in_hs[i][c]) begin
        sb_mem[i][c][sb_wr[i][c] % 4096] = src_data[i][c];
        sb_wr[i][c]++;
      end
      if (dst_valid[i][c] && snk_ready[i][c]) begin
        if (sb_rd[i][c] == sb_wr[i][c]) begin
          check({t, "_extra_beat"}, 40'(sb_wr[i][c]), 40'(sb_rd[i][c] + 1));
        end else begin
          check({t, "_order"}, dst_data[i][c], sb_mem[i][c][sb_rd[i][c] % 4096]);
          sb_rd[i][c]++;
          out_cnt[i][c]++;
        end
      end
      held[i][c]      = dst_valid[i][c] && !snk_ready[i][c];
      held_data[i][c] = dst_data[i][c];
    end
  endtask

  task automatic step(input bit rnd);
    @(negedge clk);
    for (int i = 0; i < 3; i++) for (int c = 0; c < 3; c++) begin
      if (!src_valid[i][c] || in_hs[i][c]) begin
        if (rnd) begin
          src_valid[i][c] = ($urandom_range(0, 99) < 60);
          src_data[i][c]  = rand_payload(c);
        end else if (plan_idx[i][c] < plan_len[i][c]) begin
          src_valid[i][c] = 1'b1;
          src_data[i][c]  = plan[i][c][plan_idx[i][c]];
          plan_idx[i][c]++;
        end else begin
          src_valid[i][c] = 1'b0;
        end
      end
      snk_ready[i][c] = rnd ? ($urandom_range(0, 99) < 60) : dir_ready[i][c];
    end
    #1;
    sample();
  endtask

  function automatic bit all_done();
    for (int i = 0; i < 3; i++) for (int c = 0; c < 3; c++)
      if (out_cnt[i][c] < 1000) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    rst = 1'b1;
    clear_model();
    for (int i = 0; i < 3; i++) for (int c = 0; c < 3; c++) snk_ready[i][c] = 1'b1;
    @(negedge clk);
    #1;
    check_zero("por");
    release_rst();
    step(0);
    for (int i = 1; i < 3; i++) for (int c = 0; c < 3; c++)
      check($sformatf("rise_rdy_i%0d_c%0d", i, c), src_ready[i][c], 1);

    // AW streaming through the simple buffer: one beat every other cycle.
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) plan[i][0][j] = {5'd0, 32'(4 * j), 3'd0};
      plan_len[i][0] = 3;
      plan_idx[i][0] = 0;
    end
    for (int k = 0; k < 6; k++) begin
      step(0);
      check($sformatf("aw_rdy_k%0d", k), src_ready[1][0], AW_R[k]);
      check($sformatf("aw_vld_k%0d", k), dst_valid[1][0], AW_V[k]);
      if (AW_V[k]) check($sformatf("aw_dat_k%0d", k), dst_data[1][0], {5'd0, 32'(2 * (k - 1)), 3'd0});
    end
    repeat (3) step(0);

    // B responses back-to-back through the skid buffer.
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) plan[i][2][j] = {38'd0, B_RESP[j]};
      plan_len[i][2] = 4;
      plan_idx[i][2] = 0;
    end
    for (int k = 0; k < 6; k++) begin
      step(0);
      check($sformatf("b_rdy_k%0d", k), src_ready[2][2], 1);
      check($sformatf("b_vld_k%0d", k), dst_valid[2][2], (k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) check($sformatf("b_dat_k%0d", k), dst_data[2][2], {38'd0, B_RESP[k - 1]});
    end
    repeat (3) step(0);

    // W through the skid buffer with a 3-cycle master stall after beat 1.
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) plan[i][1][j] = {4'd0, {8{4'(j + 1)}}, 4'hF};
      plan_len[i][1] = 4;
      plan_idx[i][1] = 0;
    end
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 3; i++) dir_ready[i][1] = !(k >= 1 && k <= 3);
      step(0);
      check($sformatf("w_rdy_k%0d", k), src_ready[2][1], W_R[k]);
      check($sformatf("w_vld_k%0d", k), dst_valid[2][1], (k >= 1));
      if (k >= 1) check($sformatf("w_dat_k%0d", k), dst_data[2][1], plan[2][1][W_IDX[k]]);
    end
    for (int i = 0; i < 3; i++) for (int c = 0; c < 3; c++) dir_ready[i][c] = 1'b1;
    repeat (6) step(0);
    check_empty("dir");

    // Asynchronous reset mid-cycle with an AW beat stalled at the master port.
    for (int i = 0; i < 3; i++) begin
      plan[i][0][0]   = {5'd0, 32'h100, 3'd5};
      plan_len[i][0]  = 1;
      plan_idx[i][0]  = 0;
      dir_ready[i][0] = 1'b0;
    end
    repeat (2) step(0);
    check("pre_rst_vld_i1", dst_valid[1][0], 1);
    check("pre_rst_vld_i2", dst_valid[2][0], 1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("mid");
    clear_model();
    release_rst();
    for (int k = 0; k < 2; k++) begin
      step(0);
      for (int i = 1; i < 3; i++) begin
        check($sformatf("post_rdy_i%0d_k%0d", i, k), src_ready[i][0], 1);
        check($sformatf("post_vld_i%0d_k%0d", i, k), dst_valid[i][0], 0);
      end
    end

    // Randomized stress on every channel of every register type.
    for (int i = 0; i < 3; i++) for (int c = 0; c < 3; c++) out_cnt[i][c] = 0;
    for (int cyc = 0; cyc < 30000 && !all_done(); cyc++) step(1);
    for (int i = 0; i < 3; i++) for (int c = 0; c < 3; c++) dir_ready[i][c] = 1'b1;
    repeat (20) step(0);
    check_empty("rnd");
    for (int i = 0; i < 3; i++) for (int c = 0; c < 3; c++)
      check($sformatf("rnd_beats_i%0d_c%0d", i, c), 40'(out_cnt[i][c] >= 1000), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
